lcache_sa_rle: RTL
==================

// Module: lcache_sa_rle
// PURPOSE
// - Parametrised N-way set-associative L1 data cache between CPU bench and main memory; successor to the 4-way 2KB LCache.
// - Line fills arrive as run-length packets {count, value} and are decompressed into a staging buffer before commit.
// - Adds valid/ready handshakes on every channel, round-robin replacement once a set is full, write-through stores and hit/miss counters.
// PARAMETERS
// - NUM_WAYS       4   ways per set (power of 2, >=1)
// - NUM_SETS       16  sets (power of 2)
// - WORDS_PER_LINE 8   DATA_WIDTH words per line (power of 2)
// - ADDR_WIDTH     32  word address width
// - DATA_WIDTH     32  word width
// - CNT_WIDTH      4   run-count field in fill packets; payload = DATA_WIDTH-CNT_WIDTH bits
// PORTS
// - clk           in  1   clock, rising edge
// - reset         in  1   synchronous, active-high
// - req_valid     in  1   CPU request valid
// - req_ready     out 1   high only in IDLE
// - req_we        in  1   1 = store, 0 = load
// - req_addr      in  ADDR_WIDTH  word addr {tag, index, offset}
// - req_wdata     in  DATA_WIDTH  store data
// - resp_valid    out 1   one-cycle pulse, completes request
// - resp_rdata    out DATA_WIDTH  load data; 0 for stores
// - resp_hit      out 1   request hit (qualified by resp_valid)
// - mem_rd_valid  out 1   line-read request valid
// - mem_rd_ready  in  1   memory accepts line read
// - mem_rd_addr   out ADDR_WIDTH  line base addr (offset bits zero)
// - mem_pkt_valid in  1   fill packet valid
// - mem_pkt_ready out 1   high only in FILL
// - mem_pkt_data  in  DATA_WIDTH  [DW-1 -: CNT_WIDTH] = count, rest = payload
// - mem_wr_valid  out 1   write-through valid
// - mem_wr_ready  in  1   memory accepts write
// - mem_wr_addr   out ADDR_WIDTH  store word addr
// - mem_wr_data   out DATA_WIDTH  store data
// - hit_cnt       out 16  saturating hit count
// - miss_cnt      out 16  saturating miss count
// BEHAVIOUR
// - Reset: all valid bits 0, round-robin pointers 0, counters 0, state IDLE; every output 0 except req_ready=1.
// - Arrays (tags, data) are not reset; only valid bits gate hits.
// - Accept = req_valid & req_ready. Hit test at accept: combinational on req_addr vs valid+tag of all ways; request fields latched.
// - FSM IDLE->(load hit) IDLE: resp_valid, resp_hit=1, rdata=word next cycle (latency 1).
// - IDLE->(load miss) RDREQ: mem_rd_valid held, addr stable until mem_rd_ready -> FILL.
// - FILL: each packet accepted writes min(count, remaining) copies of zero-extended payload into staging words from fill_ptr upward.
//   count=0 treated as 1; words beyond WORDS_PER_LINE discarded; fill_ptr reaching WORDS_PER_LINE -> COMMIT.
// - COMMIT (1 cycle): victim = lowest invalid way in set, else rr_ptr[set]; write staging line, tag, valid=1;
//   rr_ptr[set] += 1 (wraps) only when a valid way was evicted; -> RESP.
// - RESP: resp_valid, resp_hit=0, rdata = requested word from staging -> IDLE (miss latency = 3 + handshake + packet cycles).
// - IDLE->(store) WRITE: hit updates the word in place at accept; miss is no-allocate. mem_wr_valid held until mem_wr_ready,
//   then resp_valid, resp_hit=hit, rdata=0 -> IDLE.
// - Counters: +1 per accepted request (hit or miss), saturate at 16'hFFFF.
// - Tags compared against valid ways only; multiple matches impossible by construction.
// - Reset mid-FILL/WRITE: returns to IDLE, staging discarded, no partial line becomes valid; outstanding mem handshakes dropped.
// - Outputs registered except req_ready and mem_pkt_ready, which decode state.
// TESTING
// - Reset, load 0x0000_0083 -> miss: mem_rd_addr=0x80; packets {8,0x0000123} -> 8 words 0x123, resp_rdata=0x123, resp_hit=0, miss_cnt=1.
// - Repeat load 0x0000_0085 -> resp_valid exactly 1 cycle after accept, rdata=0x123, resp_hit=1, hit_cnt=1.
// - Packets {3,0xA},{0,0xB},{9,0xC} -> line A,A,A,B,C,C,C,C; extra C runs dropped; next packet not accepted.
// - 5 distinct tags into set 1 -> ways 0..3 fill, 5th evicts way 0, 6th evicts way 1; rr_ptr advances only on eviction.
// - Store hit 0x85 data 0xDEAD with mem_wr_ready low 4 cycles -> wr signals stable, then resp; reload 0x85 hits 0xDEAD;
//   store miss 0x4000 does not allocate (later load of 0x4000 misses).
// - Assert reset during FILL after 2 packets -> IDLE, req_ready=1; reload same addr misses again.

Source files
------------

// File: rtl/lcache_sa_rle.sv
// N-way set-associative write-through L1 data cache with run-length-encoded line fills.
// Assumes NUM_SETS >= 2 and WORDS_PER_LINE >= 2 so index/offset fields are non-empty.
module lcache_sa_rle #(
  parameter int NUM_WAYS       = 4,
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_pkt_valid,
  output logic                  mem_pkt_ready,
  input  logic [DATA_WIDTH-1:0] mem_pkt_data,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PAY_W = DATA_WIDTH - CNT_WIDTH;
  localparam int FP_W  = OFF_W + CNT_WIDTH + 1;
  localparam logic [FP_W-1:0]  LINE_WORDS = FP_W'(WORDS_PER_LINE);
  localparam logic [WAY_W-1:0] LAST_WAY   = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RDREQ, S_FILL, S_COMMIT, S_RESP, S_WRITE} state_t;
  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] data_mem  [NUM_WAYS][NUM_SETS*WORDS_PER_LINE];
  logic [TAG_W-1:0]      tag_mem   [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0]   valid_reg [NUM_WAYS];
  logic [WAY_W-1:0]      rr_reg    [NUM_SETS];
  logic [DATA_WIDTH-1:0] stage_reg [WORDS_PER_LINE];

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  hit_reg;
  logic [FP_W-1:0]       fill_ptr_reg;
  logic                  resp_valid_reg, resp_hit_reg;
  logic [DATA_WIDTH-1:0] resp_rdata_reg;
  logic                  mem_rd_valid_reg, mem_wr_valid_reg;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_reg, mem_wr_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wr_data_reg;
  logic [15:0]           hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0] req_tag, tag_reg;
  logic [IDX_W-1:0] req_idx, idx_reg;
  logic [OFF_W-1:0] req_off, off_reg;
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];
  assign tag_reg = addr_reg[ADDR_WIDTH-1 -: TAG_W];
  assign idx_reg = addr_reg[OFF_W +: IDX_W];
  assign off_reg = addr_reg[OFF_W-1:0];

  logic accept;
  assign accept = req_valid && (state_reg == S_IDLE);

  // Lookup: only valid ways may match, so at most one bit is set.
  logic [NUM_WAYS-1:0] way_match;
  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
      assign way_match[gi] = valid_reg[gi][req_idx] && (tag_mem[gi][req_idx] == req_tag);
    end
  endgenerate

  logic             req_hit;
  logic [WAY_W-1:0] hit_way;
  assign req_hit = |way_match;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_match[w]) hit_way = WAY_W'(w);
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  logic [WAY_W-1:0] victim_way, rr_next;
  logic             set_full;
  always_comb begin
    victim_way = rr_reg[idx_reg];
    set_full   = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_reg[w][idx_reg]) begin
        victim_way = WAY_W'(w);
        set_full   = 1'b0;
      end
  end
  assign rr_next = (rr_reg[idx_reg] == LAST_WAY) ? '0 : rr_reg[idx_reg] + WAY_W'(1);

  // Run-length decode: a zero count means one copy; runs past the line end are clipped.
  logic                 pkt_fire;
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic [FP_W-1:0]      run_len, fill_sum, fill_end;
  assign pkt_fire = mem_pkt_valid && (state_reg == S_FILL);
  assign pkt_cnt  = mem_pkt_data[DATA_WIDTH-1 -: CNT_WIDTH];
  assign run_len  = (pkt_cnt == '0) ? FP_W'(1) : FP_W'(pkt_cnt);
  assign fill_sum = fill_ptr_reg + run_len;
  assign fill_end = (fill_sum > LINE_WORDS) ? LINE_WORDS : fill_sum;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = req_we ? S_WRITE : (req_hit ? S_IDLE : S_RDREQ);
      S_RDREQ:  if (mem_rd_ready) state_next = S_FILL;
      S_FILL:   if (pkt_fire && fill_end == LINE_WORDS) state_next = S_COMMIT;
      S_COMMIT: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      S_WRITE:  if (mem_wr_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_reg == S_IDLE);
    mem_pkt_ready = (state_reg == S_FILL);
  end

  // Storage arrays carry no reset; valid bits alone decide whether contents are live.
  always_ff @(posedge clk) begin
    if (accept && req_we && req_hit)
      data_mem[hit_way][{req_idx, req_off}] <= req_wdata;
    if (state_reg == S_COMMIT) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        data_mem[victim_way][{idx_reg, OFF_W'(w)}] <= stage_reg[w];
      tag_mem[victim_way][idx_reg] <= tag_reg;
    end
    for (int w = 0; w < WORDS_PER_LINE; w++)
      if (pkt_fire && FP_W'(w) >= fill_ptr_reg && FP_W'(w) < fill_end)
        stage_reg[w] <= {{CNT_WIDTH{1'b0}}, mem_pkt_data[PAY_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_reg[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_reg[s] <= '0;
      addr_reg         <= '0;
      hit_reg          <= 1'b0;
      fill_ptr_reg     <= '0;
      resp_valid_reg   <= 1'b0;
      resp_hit_reg     <= 1'b0;
      resp_rdata_reg   <= '0;
      mem_rd_valid_reg <= 1'b0;
      mem_rd_addr_reg  <= '0;
      mem_wr_valid_reg <= 1'b0;
      mem_wr_addr_reg  <= '0;
      mem_wr_data_reg  <= '0;
      hit_cnt_reg      <= '0;
      miss_cnt_reg     <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (accept) begin
        addr_reg <= req_addr;
        hit_reg  <= req_hit;
        if (req_hit) begin
          if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
        end else begin
          if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
        end
        if (req_we) begin
          mem_wr_valid_reg <= 1'b1;
          mem_wr_addr_reg  <= req_addr;
          mem_wr_data_reg  <= req_wdata;
        end else if (req_hit) begin
          resp_valid_reg <= 1'b1;
          resp_hit_reg   <= 1'b1;
          resp_rdata_reg <= data_mem[hit_way][{req_idx, req_off}];
        end else begin
          mem_rd_valid_reg <= 1'b1;
          mem_rd_addr_reg  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          fill_ptr_reg     <= '0;
        end
      end
      if (state_reg == S_RDREQ && mem_rd_ready) mem_rd_valid_reg <= 1'b0;
      if (pkt_fire) fill_ptr_reg <= fill_end;
      if (state_reg == S_COMMIT) begin
        valid_reg[victim_way][idx_reg] <= 1'b1;
        if (set_full) rr_reg[idx_reg] <= rr_next;
        resp_valid_reg <= 1'b1;
        resp_hit_reg   <= 1'b0;
        resp_rdata_reg <= stage_reg[off_reg];
      end
      if (state_reg == S_WRITE && mem_wr_ready) begin
        mem_wr_valid_reg <= 1'b0;
        resp_valid_reg   <= 1'b1;
        resp_hit_reg     <= hit_reg;
        resp_rdata_reg   <= '0;
      end
    end
  end

  assign resp_valid   = resp_valid_reg;
  assign resp_rdata   = resp_rdata_reg;
  assign resp_hit     = resp_hit_reg;
  assign mem_rd_valid = mem_rd_valid_reg;
  assign mem_rd_addr  = mem_rd_addr_reg;
  assign mem_wr_valid = mem_wr_valid_reg;
  assign mem_wr_addr  = mem_wr_addr_reg;
  assign mem_wr_data  = mem_wr_data_reg;
  assign hit_cnt      = hit_cnt_reg;
  assign miss_cnt     = miss_cnt_reg;

endmodule
